// File: rtl/sbox_lane_pipe.sv
// LANES-wide AES S-box, two register stages (2-cycle latency), valid/ready with full back-pressure.
// Define SBOX_INV_EN to compile in the per-beat inverse S-box (in_inv / out_inv); otherwise forward only.
module sbox_lane_pipe #(
  parameter int LANES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [8*LANES-1:0]   in_data,
  input  logic                 in_inv,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8*LANES-1:0]   out_data,
  output logic                 out_inv,
  output logic [15:0]          beat_count
);

  // GF(2^8) arithmetic over the AES polynomial x^8+x^4+x^3+x+1
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse, and maps 0 to 0 as the S-box requires
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      r = gf_mul(r, r);
      if (i != 0) r = gf_mul(r, a);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox_fwd(input logic [7:0] a);
    logic [7:0] x;
    x = gf_inv(a);
    return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ 8'h63;
  endfunction

  logic                 s1_valid;
  logic [8*LANES-1:0]   s1_data;
  logic                 s2_valid;
  logic [8*LANES-1:0]   s2_data;
  logic [8*LANES-1:0]   lut;
  logic                 adv1;
  logic                 adv2;

  assign adv2      = ~s2_valid | out_ready;
  assign adv1      = ~s1_valid | adv2;
  assign in_ready  = adv1;
  assign out_valid = s2_valid;
  assign out_data  = s2_data;

`ifdef SBOX_INV_EN
  function automatic logic [7:0] sbox_inv(input logic [7:0] s);
    return gf_inv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
  endfunction

  logic s1_inv;
  logic s2_inv;

  always_comb begin
    lut = '0;
    for (int i = 0; i < LANES; i++) begin
      lut[8*i +: 8] = s1_inv ? sbox_inv(s1_data[8*i +: 8]) : sbox_fwd(s1_data[8*i +: 8]);
    end
  end

  // mode bit rides with its beat so forward and inverse beats can interleave
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_inv <= 1'b0;
      s2_inv <= 1'b0;
    end else begin
      if (adv2 && s1_valid) s2_inv <= s1_inv;
      if (adv1 && in_valid) s1_inv <= in_inv;
    end
  end

  assign out_inv = s2_inv;
`else
  logic unused_inv;
  assign unused_inv = in_inv;

  always_comb begin
    lut = '0;
    for (int i = 0; i < LANES; i++) begin
      lut[8*i +: 8] = sbox_fwd(s1_data[8*i +: 8]);
    end
  end

  assign out_inv = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_data    <= '0;
      s2_valid   <= 1'b0;
      s2_data    <= '0;
      beat_count <= 16'h0000;
    end else begin
      if (adv2) begin
        s2_valid <= s1_valid;
        if (s1_valid) s2_data <= lut;
      end
      if (adv1) begin
        s1_valid <= in_valid;
        if (in_valid) s1_data <= in_data;
      end
      if (s2_valid && out_ready) beat_count <= beat_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_sbox_lane_pipe.sv
// Directed bench for sbox_lane_pipe (LANES=4): vector table plus reset, back-pressure, streaming and wrap sequences.
module tb_sbox_lane_pipe;

  typedef struct {
    logic [31:0] data;
    logic        inv;
    logic [31:0] exp_data;
    logic        exp_inv;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_inv;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_inv;
  logic [15:0] beat_count;

  always #5 clk = ~clk;

  sbox_lane_pipe #(.LANES(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_inv     (in_inv),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_inv    (out_inv),
    .beat_count (beat_count)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] exp_cnt;
  logic [0:255][7:0] fips;
  vec_t        vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] d);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = fips[d[8*k +: 8]];
    return r;
  endfunction

  function automatic logic [31:0] pat(input int n);
    logic [7:0] b;
    b = 8'(n);
    return {b + 8'd192, b + 8'd128, b + 8'd64, b};
  endfunction

  // entered at a falling edge with both stages empty and out_ready=1
  task automatic run_vec(input vec_t v, input string tag);
    in_valid = 1'b1;
    in_data  = v.data;
    in_inv   = v.inv;
    #1 chk($sformatf("%s_in_ready", tag), 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk($sformatf("%s_valid_early", tag), 32'(out_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk($sformatf("%s_valid", tag), 32'(out_valid), 32'd1);
    chk($sformatf("%s_data", tag), out_data, v.exp_data);
    chk($sformatf("%s_inv", tag), 32'(out_inv), 32'(v.exp_inv));
    @(posedge clk);
    @(negedge clk);
    exp_cnt = exp_cnt + 16'd1;
    chk($sformatf("%s_count", tag), 32'(beat_count), 32'(exp_cnt));
  endtask

  initial begin
    logic        rdy;
    logic        stale;
    int          idx;
    int          n_got;
    int          sent;
    int          n_out;
    int          first;
    int          last;
    int          need;
    logic [31:0] got [8];
    logic [31:0] bp  [4];

    fips = {128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
            128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
            128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
            128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
            128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
            128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
            128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
            128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    vecs[0] = '{32'hFF530100, 1'b0, 32'h16ED7C63, 1'b0};
    vecs[1] = '{32'h00000000, 1'b0, 32'h63636363, 1'b0};
    vecs[2] = '{32'h01020304, 1'b0, 32'h7C777BF2, 1'b0};
    vecs[3] = '{32'h10203040, 1'b0, 32'hCAB70409, 1'b0};
    vecs[4] = '{32'hFFFFFFFF, 1'b0, 32'h16161616, 1'b0};
    vecs[5] = '{32'h80C0A0E0, 1'b0, 32'hCDBAE0E1, 1'b0};
`ifdef SBOX_INV_EN
    vecs[6] = '{32'h16ED7C63, 1'b1, 32'hFF530100, 1'b1};
    vecs[7] = '{32'h63636363, 1'b1, 32'h00000000, 1'b1};
`else
    // FIPS-197 forward lookups: 16->47, ED->55, 7C->10, 63->FB
    vecs[6] = '{32'h16ED7C63, 1'b1, 32'h475510FB, 1'b0};
    vecs[7] = '{32'h63636363, 1'b1, 32'hFBFBFBFB, 1'b0};
`endif
    bp[0] = 32'hFF530100;
    bp[1] = 32'h01020304;
    bp[2] = 32'hDEADBEEF;
    bp[3] = 32'h0BADF00D;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 32'h0;
    in_inv    = 1'b0;
    out_ready = 1'b1;
    exp_cnt   = 16'h0;

    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_out_inv", 32'(out_inv), 32'd0);
    chk("rst_beat_count", 32'(beat_count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));
    in_inv = 1'b0;

    // two beats in flight, then asynchronous reset mid-cycle
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h01020304;
    @(posedge clk);
    @(negedge clk);
    in_data = 32'h10203040;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("mid_full_in_ready", 32'(in_ready), 32'd0);
    chk("mid_full_out_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_out_data", out_data, 32'h0);
    chk("mid_rst_beat_count", 32'(beat_count), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    exp_cnt   = 16'h0;
    stale     = 1'b0;
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) stale = 1'b1;
    end
    chk("mid_rst_no_stale", 32'(stale), 32'd0);
    chk("mid_rst_count_after", 32'(beat_count), 32'd0);

    // back-pressure: stall output for 5 cycles with input pending
    out_ready = 1'b0;
    idx       = 0;
    in_valid  = 1'b1;
    in_data   = bp[0];
    for (int c = 0; c < 5; c++) begin
      rdy = in_ready;
      @(posedge clk);
      if (rdy) idx++;
      @(negedge clk);
      in_data = bp[idx];
      if (c >= 1) begin
        chk($sformatf("bp_hold_valid%0d", c), 32'(out_valid), 32'd1);
        chk($sformatf("bp_hold_data%0d", c), out_data, sub_word(bp[0]));
      end
    end
    chk("bp_accepted", 32'(idx), 32'd2);
    chk("bp_in_ready_full", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    #1 chk("bp_in_ready_release", 32'(in_ready), 32'd1);
    n_got = 0;
    for (int k = 0; k < 10; k++) begin
      if (out_valid) begin
        if (n_got < 8) got[n_got] = out_data;
        n_got++;
      end
      rdy = in_ready;
      @(posedge clk);
      if (in_valid && rdy) idx++;
      @(negedge clk);
      if (idx < 4) in_data = bp[idx];
      else in_valid = 1'b0;
    end
    chk("bp_delivered", 32'(n_got), 32'd4);
    for (int j = 0; j < 4; j++) chk($sformatf("bp_order%0d", j), got[j], sub_word(bp[j]));
    exp_cnt = exp_cnt + 16'd4;
    chk("bp_count", 32'(beat_count), 32'(exp_cnt));

    // 256 back-to-back beats
    sent  = 0;
    n_out = 0;
    first = -1;
    last  = -1;
    for (int cyc = 0; cyc < 270; cyc++) begin
      if (out_valid) begin
        chk($sformatf("str_beat%0d", n_out), out_data, sub_word(pat(n_out)));
        if (first < 0) first = cyc;
        last = cyc;
        n_out++;
      end
      in_valid = (sent < 256);
      in_data  = pat(sent);
      rdy      = in_ready;
      @(posedge clk);
      if (in_valid && rdy) sent++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("str_outputs", 32'(n_out), 32'd256);
    chk("str_no_bubbles", 32'(last - first), 32'd255);
    exp_cnt = exp_cnt + 16'd256;
    chk("str_count", 32'(beat_count), 32'(exp_cnt));

    // run the counter up to 0xFFFF, then one more beat must wrap it
    need = 32'hFFFF - int'(exp_cnt);
    sent = 0;
    for (int c = 0; c < 70000 && beat_count != 16'hFFFF; c++) begin
      in_valid = (sent < need);
      in_data  = pat(sent);
      rdy      = in_ready;
      @(posedge clk);
      if (in_valid && rdy) sent++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("wrap_pre_count", 32'(beat_count), 32'h0000FFFF);
    chk("wrap_pre_drained", 32'(out_valid), 32'd0);
    exp_cnt = 16'hFFFF;
    run_vec(vecs[0], "wrap");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
